// File: rtl/dec_lag3_fsm.sv
// Pitch-lag decoder: turns the received adaptive-codebook index into integer lag t0
// and fractional lag frac (thirds), tracking the T0_min/T0_max window and old_T0.
module dec_lag3_fsm #(
    parameter int PIT_MIN     = 20,
    parameter int PIT_MAX     = 143,
    parameter int OLD_T0_INIT = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  index,
    input  logic        i_subfr,
    input  logic        bad_lag,
    output logic [15:0] t0,
    output logic [15:0] frac,
    output logic [15:0] t0_min,
    output logic [15:0] t0_max,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_BOUND = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [15:0] PMIN16 = 16'(PIT_MIN);
    localparam logic [15:0] PMAX16 = 16'(PIT_MAX);
    localparam logic [15:0] OLD16  = 16'(OLD_T0_INIT);

    logic [2:0]  state_reg;
    logic [7:0]  index_reg;
    logic        subfr_reg;
    logic        bad_reg;
    logic [15:0] s_reg;
    logic [15:0] q_reg;
    logic [15:0] old_t0_reg;
    logic [15:0] t0_reg;
    logic [15:0] frac_reg;
    logic [15:0] t0_min_reg;
    logic [15:0] t0_max_reg;
    logic        done_reg;

    logic [15:0] idx_ext;
    logic [31:0] prod;
    logic [15:0] q_next;
    logic [15:0] k_calc;
    logic [15:0] t0_next;
    logic [15:0] frac_next;
    logic [15:0] lo_calc;
    logic [15:0] t0_min_next;
    logic [15:0] t0_max_next;

    // Subframe 1 carries only a 5-bit relative index.
    assign idx_ext = subfr_reg ? {11'd0, index_reg[4:0]} : {8'd0, index_reg};

    // 10923/32768 ~ 1/3; exact floor(s/3) for every s the index can produce.
    assign prod   = 32'(s_reg) * 32'd10923;
    assign q_next = 16'(prod >> 15);

    always_comb begin
        k_calc    = q_reg - 16'd1;
        t0_next   = old_t0_reg;
        frac_next = 16'd0;
        if (!bad_reg) begin
            if (!subfr_reg) begin
                if (index_reg < 8'd197) begin
                    t0_next   = q_reg + 16'd19;
                    frac_next = idx_ext - 16'd3 * t0_next + 16'd58;
                end else begin
                    t0_next   = idx_ext - 16'd112;
                    frac_next = 16'd0;
                end
            end else begin
                t0_next   = t0_min_reg + k_calc;
                frac_next = idx_ext - 16'd2 - 16'd3 * k_calc;
            end
        end
    end

    always_comb begin
        lo_calc     = t0_reg - 16'd5;
        t0_min_next = ($signed(lo_calc) < $signed(PMIN16)) ? PMIN16 : lo_calc;
        t0_max_next = t0_min_next + 16'd9;
        if (t0_max_next > PMAX16) begin
            t0_max_next = PMAX16;
            t0_min_next = PMAX16 - 16'd9;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            index_reg  <= 8'd0;
            subfr_reg  <= 1'b0;
            bad_reg    <= 1'b0;
            s_reg      <= 16'd0;
            q_reg      <= 16'd0;
            old_t0_reg <= OLD16;
            t0_reg     <= 16'd0;
            frac_reg   <= 16'd0;
            t0_min_reg <= 16'd0;
            t0_max_reg <= 16'd0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        index_reg <= index;
                        subfr_reg <= i_subfr;
                        bad_reg   <= bad_lag;
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    s_reg     <= idx_ext + 16'd2;
                    state_reg <= S_MUL;
                end
                S_MUL: begin
                    q_reg     <= q_next;
                    state_reg <= S_CALC;
                end
                S_CALC: begin
                    t0_reg   <= t0_next;
                    frac_reg <= frac_next;
                    // Erased frames repeat old_T0 and let it creep upward.
                    if (bad_reg && (old_t0_reg < PMAX16)) begin
                        old_t0_reg <= old_t0_reg + 16'd1;
                    end
                    state_reg <= S_BOUND;
                end
                S_BOUND: begin
                    if (!subfr_reg) begin
                        t0_min_reg <= t0_min_next;
                        t0_max_reg <= t0_max_next;
                    end
                    if (!bad_reg) begin
                        old_t0_reg <= t0_reg;
                    end
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign t0     = t0_reg;
    assign frac   = frac_reg;
    assign t0_min = t0_min_reg;
    assign t0_max = t0_max_reg;
    assign done   = done_reg;

endmodule

// File: doc/dec_lag3_fsm.md
Name: dec_lag3_fsm

Overview:
- Decoder-side pitch-lag decoder for the G.729 decoder.
- Converts the received adaptive-codebook index (8-bit in subframe 0, 5-bit in subframe 1) into integer lag t0 and fractional lag frac (-1/0/+1, in thirds).
- Keeps the T0_min/T0_max search window and old_T0 across subframes; mirrors the encoder's lag quantiser.
- Outputs feed the decoder's Pred_lt_3 instance directly; start/done handshake like the other arithmetic blocks.

Parameters:
PIT_MIN, 20, minimum pitch lag
PIT_MAX, 143, maximum pitch lag
OLD_T0_INIT, 60, reset value of stored old_T0

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle request, sampled only in IDLE
index  input  8  received lag index; subframe 1 uses index[4:0], index[7:5] ignored
i_subfr  input  1  0 = first subframe, 1 = second subframe
bad_lag  input  1  frame erased or parity error; sampled with start
t0  output  16  decoded integer lag, unsigned
frac  output  16  decoded fraction, two's complement (-1 = 16'hFFFF)
t0_min  output  16  current window lower bound
t0_max  output  16  current window upper bound
done  output  1  one-cycle pulse; outputs valid from this cycle

Behaviour:
- Reset (async, reset=0) forces:
  - state IDLE, done=0, t0=0, frac=0, t0_min=0, t0_max=0
  - old_T0=OLD_T0_INIT
- FSM: IDLE -> LOAD -> MUL -> CALC -> BOUND -> DONE -> IDLE.
  - start=1 in IDLE captures index, i_subfr and bad_lag.
  - done is asserted exactly 5 cycles after the start edge and lasts one cycle.
  - start outside IDLE is ignored.
- LOAD: s = index+2, zero-extended to 16 bits (subframe 1 uses index[4:0]).
- MUL: p = s*10923 as a 32-bit product; q = p>>15 (equals floor(s/3) over the valid range).
- CALC, bad_lag=1 (either subframe):
  - t0=old_T0, frac=0
  - old_T0 = old_T0+1 if old_T0<PIT_MAX, else unchanged
- CALC, subframe 0, bad_lag=0:
  - index<197: t0 = q+19, frac = index - 3*t0 + 58
  - index>=197: t0 = index-112, frac = 0
- CALC, subframe 1, bad_lag=0:
  - k = q-1 (signed; may be -1)
  - t0 = t0_min+k, frac = index[4:0] - 2 - 3*k
- Arithmetic is 16-bit two's complement.
- BOUND, subframe 0 only (including the bad_lag case):
  - t0_min = max(t0-5, PIT_MIN), then t0_max = t0_min+9
  - if t0_max>PIT_MAX: t0_max=PIT_MAX, t0_min=PIT_MAX-9
- BOUND, subframe 1: t0_min and t0_max are unchanged.
- BOUND, any good frame (bad_lag=0): old_T0=t0.
- t0, frac, t0_min and t0_max hold their values until the next CALC/BOUND; they are not cleared at IDLE.
- Reset mid-operation aborts immediately: no done pulse, and every register returns to its reset value.

Test Plan:
1. Reset, then sf0 index=0 -> done at cycle +5; t0=19, frac=1, t0_min=20, t0_max=29, old_T0=19.
2. sf0 index=100 -> t0=53, frac=16'hFFFF, t0_min=48, t0_max=57; then sf1 index=17 -> t0=53, frac=0; then sf1 index=31 -> t0=58, frac=16'hFFFF; then sf1 index=0 -> t0=47, frac=1. t0_min/t0_max stay 48/57 throughout.
3. sf0 index=200 -> t0=88, frac=0, window 83..92. sf0 index=255 -> t0=143, frac=0, t0_min=134, t0_max=143 (upper clamp).
4. Erasure after reset: sf0 bad_lag=1 -> t0=60, frac=0, window 55..64, old_T0=61. A second bad_lag sf0 -> t0=61. With old_T0 at 143, bad_lag -> t0=143 and old_T0 stays 143.
5. Handshake: start pulsed again at cycles +1..+4 -> ignored, exactly one done. Reset driven low at MUL -> no done, all outputs 0; next start works normally.
